// File: rtl/traffic_timer_bank.sv
// traffic_timer_bank: prescaled timebase and divided clock driving a bank of independent down-counting timers
module traffic_timer_bank #(
    parameter int CLK_DIV    = 5,
    parameter int NUM_TIMERS = 4,
    parameter int CNT_W      = 8
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_pause,
    input  logic [NUM_TIMERS-1:0]       i_start,
    input  logic [NUM_TIMERS-1:0]       i_clear,
    input  logic [NUM_TIMERS*CNT_W-1:0] i_duration,
    output logic                        o_tick,
    output logic                        o_clk,
    output logic [NUM_TIMERS-1:0]       o_busy,
    output logic [NUM_TIMERS-1:0]       o_expired,
    output logic [NUM_TIMERS-1:0]       o_done,
    output logic [NUM_TIMERS*CNT_W-1:0] o_count
);
    localparam int PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;

    logic [PW-1:0]         presc;
    logic [NUM_TIMERS-1:0] start_prev;
    logic [NUM_TIMERS-1:0] start_edge;

    assign o_tick     = (presc == LAST) & ~i_pause;
    assign start_edge = i_start & ~start_prev;

    // Timebase: prescaler and divided clock freeze under pause; start history tracks every cycle
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            presc      <= '0;
            o_clk      <= 1'b0;
            start_prev <= '1;
        end else begin
            start_prev <= i_start;
            if (!i_pause) presc <= o_tick ? '0 : presc + 1'b1;
            if (o_tick) o_clk <= ~o_clk;
        end
    end

    for (genvar k = 0; k < NUM_TIMERS; k++) begin : g_ch
        state_t             state, state_nx;
        logic [CNT_W-1:0]   cnt, cnt_nx;
        logic               done, done_nx;
        logic [CNT_W-1:0]   dur;

        assign dur = i_duration[k*CNT_W +: CNT_W];

        // Channel state register
        always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) begin
                state <= IDLE;
                cnt   <= '0;
                done  <= 1'b0;
            end else begin
                state <= state_nx;
                cnt   <= cnt_nx;
                done  <= done_nx;
            end
        end

        // Next state: clear beats a start edge, a start edge beats the tick
        always_comb begin
            state_nx = state;
            cnt_nx   = cnt;
            done_nx  = 1'b0;
            if (i_clear[k]) begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end else if (start_edge[k]) begin
                state_nx = (dur != '0) ? RUN : EXPIRED;
                cnt_nx   = dur;
                done_nx  = (dur == '0);
            end else if (state == RUN && o_tick) begin
                state_nx = (cnt > CNT_W'(1)) ? RUN : EXPIRED;
                cnt_nx   = (cnt > CNT_W'(1)) ? cnt - 1'b1 : '0;
                done_nx  = (cnt <= CNT_W'(1));
            end
        end

        assign o_busy[k]                    = (state == RUN);
        assign o_expired[k]                 = (state == EXPIRED);
        assign o_done[k]                    = done;
        assign o_count[k*CNT_W +: CNT_W]    = cnt;
    end
endmodule

// File: tb/tb_traffic_timer_bank.sv
// tb_traffic_timer_bank: scoreboard bench comparing the timer bank against a cycle model
module tb_traffic_timer_bank;
    localparam int DIV = 5;
    localparam int N   = 2;
    localparam int W   = 8;

    logic           clk   = 1'b0;
    logic           rst   = 1'b1;
    logic           pause = 1'b0;
    logic [N-1:0]   start = '0;
    logic [N-1:0]   clear = '0;
    logic [N*W-1:0] dur   = '0;
    logic           o_tick, o_clk;
    logic [N-1:0]   o_busy, o_expired, o_done;
    logic [N*W-1:0] o_count;

    traffic_timer_bank #(.CLK_DIV(DIV), .NUM_TIMERS(N), .CNT_W(W)) dut (
        .i_clk(clk), .i_reset(rst), .i_pause(pause), .i_start(start), .i_clear(clear),
        .i_duration(dur), .o_tick(o_tick), .o_clk(o_clk), .o_busy(o_busy),
        .o_expired(o_expired), .o_done(o_done), .o_count(o_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           presc;
        logic         oclk;
        logic [N-1:0] busy, expd, done;
        logic [N*W-1:0] cnt;
    } snap_t;

    snap_t sb[$];

    int           m_presc = 0;
    logic         m_clk   = 1'b0;
    int           m_st[N];
    int           m_cnt[N];
    logic [N-1:0] m_done  = '0;
    logic [N-1:0] m_prev  = '1;

    int   checks = 0, errors = 0, cyc = 0;
    int   dn[N];
    int   dc[N];
    int   ticks[$];
    int   rises[$];
    logic tick_seen = 1'b0;
    logic prev_oclk = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic snap_t snap();
        snap_t s;
        s.presc = m_presc;
        s.oclk  = m_clk;
        s.done  = m_done;
        for (int k = 0; k < N; k++) begin
            s.busy[k]       = (m_st[k] == 1);
            s.expd[k]       = (m_st[k] == 2);
            s.cnt[k*W +: W] = W'(m_cnt[k]);
        end
        return s;
    endfunction

    task automatic model_step();
        logic tk;
        if (rst) begin
            m_presc = 0;
            m_clk   = 1'b0;
            m_prev  = '1;
            m_done  = '0;
            for (int k = 0; k < N; k++) begin
                m_st[k]  = 0;
                m_cnt[k] = 0;
            end
            return;
        end
        tk = (m_presc == DIV - 1) && !pause;
        if (!pause) m_presc = (m_presc == DIV - 1) ? 0 : m_presc + 1;
        if (tk) m_clk = ~m_clk;
        for (int k = 0; k < N; k++) begin
            int d;
            d = int'(dur[k*W +: W]);
            m_done[k] = 1'b0;
            if (clear[k]) begin
                m_st[k]  = 0;
                m_cnt[k] = 0;
            end else if (start[k] && !m_prev[k]) begin
                m_st[k]   = (d != 0) ? 1 : 2;
                m_cnt[k]  = d;
                m_done[k] = (d == 0);
            end else if (m_st[k] == 1 && tk) begin
                if (m_cnt[k] == 1) begin
                    m_st[k]   = 2;
                    m_done[k] = 1'b1;
                end
                m_cnt[k] = m_cnt[k] - 1;
            end
        end
        m_prev = start;
    endtask

    // One cycle: predict the post-edge state, then compare the DUT just after the edge
    task automatic step();
        snap_t e;
        model_step();
        sb.push_back(snap());
        @(posedge clk);
        #1;
        cyc++;
        e = sb.pop_front();
        check("tick", o_tick, (e.presc == DIV - 1) && !pause);
        check("oclk", o_clk, e.oclk);
        check("busy", o_busy, e.busy);
        check("expired", o_expired, e.expd);
        check("done", o_done, e.done);
        check("count", o_count, e.cnt);
        if (o_tick) ticks.push_back(cyc);
        if (o_clk && !prev_oclk) rises.push_back(cyc);
        prev_oclk = o_clk;
        tick_seen = o_tick;
        for (int k = 0; k < N; k++)
            if (o_done[k]) begin
                dn[k]++;
                dc[k] = cyc;
            end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic wait_tick();
        int i = 0;
        do begin
            step();
            i++;
        end while (!tick_seen && i < 4 * DIV);
        check("wait_tick", tick_seen, 1);
    endtask

    task automatic wait_done(input int k);
        int d = dn[k];
        int i = 0;
        do begin
            step();
            i++;
        end while (dn[k] == d && i < 80);
        check("wait_done", dn[k] != d, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, s, lu, lp;
        for (int k = 0; k < N; k++) begin
            dn[k] = 0;
            dc[k] = 0;
        end
        // reset and timebase
        run(20);
        rst = 1'b0;
        ticks.delete();
        rises.delete();
        run(30);
        check("tick_n", ticks.size() >= 3, 1);
        if (ticks.size() >= 3) begin
            check("tick_per0", ticks[1] - ticks[0], DIV);
            check("tick_per1", ticks[2] - ticks[1], DIV);
        end
        check("rise_n", rises.size() >= 2, 1);
        if (rises.size() >= 2) check("oclk_per", rises[1] - rises[0], 2 * DIV);
        // basic expiry on ch0, D=3
        dur[0 +: W] = 8'd3;
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        check("t2_busy", o_busy[0], 1);
        check("t2_load", o_count[0 +: W], 3);
        run(25);
        check("t2_done_n", dn[0], 1);
        check("t2_expired", o_expired[0], 1);
        check("t2_ch1_idle", {o_busy[1], o_expired[1]}, 0);
        // retrigger: D=6, two ticks, reload with D=4
        clear[0] = 1'b1;
        step();
        clear[0] = 1'b0;
        dur[0 +: W] = 8'd6;
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        wait_tick();
        step();
        wait_tick();
        step();
        check("t3_after2", o_count[0 +: W], 4);
        dur[0 +: W] = 8'd4;
        start[0] = 1'b1;
        d0 = dn[0];
        step();
        start[0] = 1'b0;
        check("t3_reload", o_count[0 +: W], 4);
        run(14);
        check("t3_no_early", dn[0], d0);
        run(10);
        check("t3_done", dn[0], d0 + 1);
        // zero duration with start held high
        clear[0] = 1'b1;
        step();
        clear[0] = 1'b0;
        dur[0 +: W] = 8'd0;
        start[0] = 1'b1;
        d0 = dn[0];
        run(30);
        check("t4_one_done", dn[0], d0 + 1);
        check("t4_expired", o_expired[0], 1);
        check("t4_not_busy", o_busy[0], 0);
        start[0] = 1'b0;
        step();
        // pause delays ch1 expiry by exactly the paused cycles
        clear[1] = 1'b1;
        step();
        clear[1] = 1'b0;
        dur[W +: W] = 8'd2;
        wait_tick();
        start[1] = 1'b1;
        step();
        s = cyc;
        start[1] = 1'b0;
        wait_done(1);
        lu = dc[1] - s;
        clear[1] = 1'b1;
        step();
        clear[1] = 1'b0;
        wait_tick();
        start[1] = 1'b1;
        step();
        s = cyc;
        start[1] = 1'b0;
        run(2);
        pause = 1'b1;
        #1;
        check("t5_tick_off", o_tick, 0);
        run(12);
        pause = 1'b0;
        wait_done(1);
        lp = dc[1] - s;
        check("t5_delay", lp - lu, 12);
        // clear beats simultaneous start edge and tick
        dur[0 +: W] = 8'd5;
        wait_tick();
        clear[0] = 1'b1;
        start[0] = 1'b1;
        step();
        check("t6_clr_busy", o_busy[0], 0);
        check("t6_clr_count", o_count[0 +: W], 0);
        clear[0] = 1'b0;
        start[0] = 1'b0;
        step();
        // reset mid-run with start held through release
        dur[0 +: W] = 8'd9;
        start[0] = 1'b1;
        run(8);
        check("t6_running", o_busy[0], 1);
        d0 = dn[0];
        rst = 1'b1;
        #1;
        check("t6_rst_busy", o_busy[0], 0);
        check("t6_rst_count", o_count[0 +: W], 0);
        run(3);
        rst = 1'b0;
        run(60);
        check("t6_no_done", dn[0], d0);
        check("t6_no_restart", {o_busy[0], o_expired[0]}, 0);
        start[0] = 1'b0;
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
